// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer.
// Pulses the PLL reset, waits for lock, and requires a run of consecutive
// locked cycles before any domain leaves reset. The four output-clock domain
// resets are then released one at a time in the order 0,1,2,3. After that the
// sequencer watches lock: a loss of lock pulls every domain back into reset and
// the whole sequence runs again.
//
// Lock timeouts are retried. When the retries run out the block parks in FAIL
// until relock_req or rst arrives.
//
// Handshake: relock_req is a single-cycle strobe with no ready. It is sampled
// on every rising refclk edge, wins over everything except rst, and always takes
// effect on that same edge.
//
// Every output comes straight from a flop. The FSM computes the next value of
// each output together with the next state, so a decision made on edge N is
// visible right after edge N.

module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 742500,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic [3:0] domain_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] lock_lost_count,
    output logic [2:0] state_dbg
);

    // One shared phase counter serves every timed state. It is sized for the
    // longest phase, so it never wraps before any terminal count is reached.
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_n;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_n;
    logic               pll_rst_n;
    logic [3:0]         domain_rst_n;
    logic               ready_n;
    logic               fail_n;
    logic [7:0]         lock_lost_n;

    logic sync_q;
    logic locked_s;

    assign state_dbg = state_q;

    // Two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= pll_locked;
            locked_s <= sync_q;
        end
    end

    // Next-state and next-output logic. The priority is relock_req, then
    // lock loss or timeout, then normal progression.
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        retry_n      = retry_q;
        pll_rst_n    = pll_rst;
        domain_rst_n = domain_rst;
        ready_n      = ready;
        fail_n       = fail;
        lock_lost_n  = lock_lost_count;

        if (relock_req) begin
            state_n      = S_PLL_RST;
            cnt_n        = '0;
            retry_n      = '0;
            pll_rst_n    = 1'b1;
            domain_rst_n = 4'hF;
            ready_n      = 1'b0;
            fail_n       = 1'b0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    pll_rst_n    = 1'b1;
                    domain_rst_n = 4'hF;
                    ready_n      = 1'b0;
                    if (cnt_q == PLL_RST_LAST) begin
                        state_n   = S_WAIT_LOCK;
                        cnt_n     = '0;
                        pll_rst_n = 1'b0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_n = S_STABLE;
                        cnt_n   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_n = '0;
                        if (retry_q == RETRY_LIMIT) begin
                            state_n   = S_FAIL;
                            fail_n    = 1'b1;
                            pll_rst_n = 1'b0;
                        end else begin
                            state_n   = S_PLL_RST;
                            retry_n   = retry_q + RETRY_W'(1);
                            pll_rst_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end

                S_STABLE: begin
                    if (!locked_s) begin
                        // A glitch restarts the wait with a fresh timeout.
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        // Domain 0 leaves reset on the first RELEASE cycle.
                        state_n      = S_RELEASE;
                        cnt_n        = '0;
                        domain_rst_n = 4'b1110;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end

                S_RELEASE: begin
                    if (!locked_s) begin
                        state_n      = S_PLL_RST;
                        cnt_n        = '0;
                        pll_rst_n    = 1'b1;
                        domain_rst_n = 4'hF;
                        ready_n      = 1'b0;
                        if (lock_lost_count != 8'hFF) begin
                            lock_lost_n = lock_lost_count + 8'd1;
                        end
                    end else if (cnt_q == STAGGER_LAST) begin
                        // The reset mask shifts left, so the domains are
                        // released in index order.
                        cnt_n        = '0;
                        domain_rst_n = {domain_rst[2:0], 1'b0};
                        if (domain_rst == 4'b1000) begin
                            state_n = S_RUN;
                            ready_n = 1'b1;
                            retry_n = '0;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (!locked_s) begin
                        state_n      = S_PLL_RST;
                        cnt_n        = '0;
                        pll_rst_n    = 1'b1;
                        domain_rst_n = 4'hF;
                        ready_n      = 1'b0;
                        if (lock_lost_count != 8'hFF) begin
                            lock_lost_n = lock_lost_count + 8'd1;
                        end
                    end
                end

                S_FAIL: begin
                    pll_rst_n    = 1'b0;
                    domain_rst_n = 4'hF;
                    ready_n      = 1'b0;
                    fail_n       = 1'b1;
                end

                default: begin
                    state_n      = S_PLL_RST;
                    cnt_n        = '0;
                    pll_rst_n    = 1'b1;
                    domain_rst_n = 4'hF;
                    ready_n      = 1'b0;
                    fail_n       = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q         <= S_PLL_RST;
            cnt_q           <= '0;
            retry_q         <= '0;
            pll_rst         <= 1'b1;
            domain_rst      <= 4'hF;
            ready           <= 1'b0;
            fail            <= 1'b0;
            lock_lost_count <= 8'd0;
        end else begin
            state_q         <= state_n;
            cnt_q           <= cnt_n;
            retry_q         <= retry_n;
            pll_rst         <= pll_rst_n;
            domain_rst      <= domain_rst_n;
            ready           <= ready_n;
            fail            <= fail_n;
            lock_lost_count <= lock_lost_n;
        end
    end

endmodule
